// File: rtl/adc_pkt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_pkt_pkg: constants, FSM encoding and header layout for adc_axis_packetizer
// Rev 1.0
// ----------------------------------------------------------------------------
package adc_pkt_pkg;

  localparam logic [15:0] PKT_MAGIC      = 16'hA5C3;
  localparam int          HDR_BEATS      = 2;
  localparam int          FLAG_CKSUM_BIT = 0;

  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_SEQ_LSB   = 32;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_FLAGS_LSB = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR0    = 3'd1;
  localparam logic [2:0] ST_HDR1    = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_PAD     = 3'd4;
  localparam logic [2:0] ST_TRL     = 3'd5;

  function automatic logic [63:0] build_hdr0(input logic [15:0] seq,
                                             input logic [15:0] len,
                                             input logic [7:0]  flags);
    logic [63:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = PKT_MAGIC;
    h[HDR_SEQ_LSB   +: 16] = seq;
    h[HDR_LEN_LSB   +: 16] = len;
    h[HDR_FLAGS_LSB +: 8]  = flags;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_skid_buffer: 2-entry registered AXI-Stream stage (data/last/user)
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic                  in_user_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  out_user_o,
  output logic                  empty_o
);

  localparam int W = DATA_WIDTH + 2;

  logic [W-1:0] out_q, skid_q;
  logic         out_vld_q, skid_vld_q;
  logic         in_fire, out_load;

  // Ready depends only on the skid register, so it never sees out_ready_i.
  assign in_ready_o = ~skid_vld_q;
  assign in_fire    = in_valid_i & ~skid_vld_q;
  assign out_load   = ~out_vld_q | out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_load) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= in_fire;
        if (in_fire) out_q <= {in_user_i, in_last_i, in_data_i};
      end
    end else if (in_fire) begin
      skid_q     <= {in_user_i, in_last_i, in_data_i};
      skid_vld_q <= 1'b1;
    end
  end

  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_q[DATA_WIDTH-1:0];
  assign out_last_o  = out_q[DATA_WIDTH];
  assign out_user_o  = out_q[DATA_WIDTH+1];
  assign empty_o     = ~out_vld_q & ~skid_vld_q;

endmodule
`default_nettype wire

// File: rtl/adc_axis_packetizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_axis_packetizer: frames the 64-bit ADC stream into headered, padded packets.
// Optional checksum trailer: define ADC_PKT_CHECKSUM_EN.          Rev 1.0
// ----------------------------------------------------------------------------
module adc_axis_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int LEN_WIDTH     = 16,
  parameter int TS_WIDTH      = 48,
  parameter int MAX_PKT_WORDS = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  input  logic                    cfg_enable,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  output logic [LEN_WIDTH-1:0]    stat_seq,
  output logic [31:0]             stat_pkt_count,
  output logic                    stat_busy
);

`ifdef ADC_PKT_CHECKSUM_EN
  localparam logic CKSUM_EN = 1'b1;
`else
  localparam logic CKSUM_EN = 1'b0;
`endif

  localparam logic [7:0]           HDR_FLAGS = CKSUM_EN ? (8'd1 << FLAG_CKSUM_BIT) : 8'd0;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_PKT_WORDS);
  localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);

  logic [2:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, wcnt_q, wcnt_d, vcnt_q, vcnt_d, seq_q;
  logic [TS_WIDTH-1:0]   ts_q, ts_lat_q, ts_lat_d;
  logic [31:0]           xor_q, xor_d, pkt_cnt_q;

  logic                  sk_valid, sk_ready, sk_last, sk_user, sk_empty;
  logic [DATA_WIDTH-1:0] sk_data;
  logic [LEN_WIDTH-1:0]  wcnt_inc;
  logic                  at_end, last_fire;

  assign wcnt_inc  = wcnt_q + ONE;
  assign at_end    = (wcnt_inc == len_q);
  assign last_fire = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    ts_lat_d      = ts_lat_q;
    wcnt_d        = wcnt_q;
    vcnt_d        = vcnt_q;
    xor_d         = xor_q;
    sk_valid      = 1'b0;
    sk_data       = '0;
    sk_last       = 1'b0;
    sk_user       = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Waiting for the output stage to drain keeps seq_q current for the next header.
        if (cfg_enable && s_axis_tvalid && sk_empty) begin
          state_d  = ST_HDR0;
          len_d    = (cfg_pkt_len == '0 || cfg_pkt_len > MAX_LEN) ? MAX_LEN : cfg_pkt_len;
          ts_lat_d = ts_q;
        end
      end
      ST_HDR0: begin
        sk_valid = 1'b1;
        sk_data  = build_hdr0(seq_q, len_q, HDR_FLAGS);
        if (sk_ready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        sk_valid = 1'b1;
        sk_data  = {{(DATA_WIDTH-TS_WIDTH){1'b0}}, ts_lat_q};
        if (sk_ready) begin
          state_d = ST_PAYLOAD;
          wcnt_d  = '0;
          vcnt_d  = '0;
          xor_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        s_axis_tready = sk_ready;
        sk_valid      = s_axis_tvalid;
        sk_data       = s_axis_tdata;
        sk_last       = ~CKSUM_EN & at_end;
        if (s_axis_tvalid && sk_ready) begin
          wcnt_d = wcnt_inc;
          vcnt_d = vcnt_q + ONE;
          xor_d  = xor_q ^ s_axis_tdata[63:32] ^ s_axis_tdata[31:0];
          if (at_end)            state_d = CKSUM_EN ? ST_TRL : ST_IDLE;
          else if (s_axis_tlast) state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        sk_valid = 1'b1;
        sk_user  = 1'b1;
        sk_last  = ~CKSUM_EN & at_end;
        if (sk_ready) begin
          wcnt_d = wcnt_inc;
          if (at_end) state_d = CKSUM_EN ? ST_TRL : ST_IDLE;
        end
      end
      ST_TRL: begin
        sk_valid = 1'b1;
        sk_data  = {16'h0000, vcnt_q[15:0], xor_q};
        sk_last  = 1'b1;
        if (sk_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      ts_q      <= '0;
      ts_lat_q  <= '0;
      wcnt_q    <= '0;
      vcnt_q    <= '0;
      xor_q     <= '0;
      seq_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ts_q     <= ts_q + TS_WIDTH'(1);
      ts_lat_q <= ts_lat_d;
      wcnt_q   <= wcnt_d;
      vcnt_q   <= vcnt_d;
      xor_q    <= xor_d;
      if (last_fire) begin
        seq_q <= seq_q + ONE;
        if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk         (aclk),
    .rst_n       (aresetn),
    .in_valid_i  (sk_valid),
    .in_ready_o  (sk_ready),
    .in_data_i   (sk_data),
    .in_last_i   (sk_last),
    .in_user_i   (sk_user),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready),
    .out_data_o  (m_axis_tdata),
    .out_last_o  (m_axis_tlast),
    .out_user_o  (m_axis_tuser),
    .empty_o     (sk_empty)
  );

  assign m_axis_tkeep   = {(DATA_WIDTH/8){m_axis_tvalid}};
  assign stat_seq       = seq_q;
  assign stat_pkt_count = pkt_cnt_q;
  assign stat_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_axis_packetizer.sv
`default_nettype none
// tb_adc_axis_packetizer: randomized scoreboard bench; the reference model
// builds whole expected packets from the framing rules at stimulus time.
module tb_adc_axis_packetizer;

  localparam int MAXW = 1024;
`ifdef ADC_PKT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tuser;
  logic        m_tready = 1'b1;
  logic        cfg_enable = 1'b1;
  logic [15:0] cfg_pkt_len = 16'd4;
  logic [15:0] stat_seq;
  logic [31:0] stat_pkt_count;
  logic        stat_busy;

  adc_axis_packetizer dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .m_axis_tready  (m_tready),
    .cfg_enable     (cfg_enable),
    .cfg_pkt_len    (cfg_pkt_len),
    .stat_seq       (stat_seq),
    .stat_pkt_count (stat_pkt_count),
    .stat_busy      (stat_busy)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        user;
    bit          is_ts;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_seq = '0;
  int          exp_pkts = 0;
  int          cyc = 0;
  longint      last_ts = 0;
  bit          ts_seen = 1'b0;
  bit          rnd_ready = 1'b0;
  int          gap_max = 0;

  initial forever #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    if (!aresetn) cyc = 0;
    else cyc++;
  end

  initial forever begin
    @(posedge aclk);
    #1;
    m_tready = rnd_ready ? 1'($urandom % 2) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: pops the scoreboard on every m transfer and checks hold-while-stalled.
  initial begin
    beat_t       e;
    bit          prev_stall = 1'b0;
    logic [65:0] prev_beat = '0;
    longint      ts;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, prev_beat});
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_beat");
            $display("FAIL unexpected_beat_data: got %h", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_ctrl", {m_tkeep, m_tuser, m_tlast}, {8'hFF, e.user, e.last});
            if (e.is_ts) begin
              ts = longint'(m_tdata[47:0]);
              n_cmp++;
              if (m_tdata[63:48] != 16'h0 || (ts_seen && ts <= last_ts) || ts >= longint'(cyc)) begin
                n_err++;
                $display("FAIL hdr1_ts: got %h required upper zero, ts > %0d and < %0d",
                         m_tdata, last_ts, cyc);
              end
              last_ts = ts;
              ts_seen = 1'b1;
            end else begin
              check("beat_data", m_tdata, e.data);
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = {m_tuser, m_tlast, m_tdata};
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic l);
    int g;
    int guard;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    s_tvalid = 1'b0;
    repeat (g) begin
      @(posedge aclk);
      #1;
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    guard    = 0;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      guard++;
      if (guard > 5000) begin
        timeout("s_accept");
        s_tvalid = 1'b0;
        return;
      end
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Model one packet: n source beats framed into a len-beat payload, then drive them.
  task automatic run_pkt(input int len_cfg, input int n, input bit last_at_end,
                         input int drop_at, input int abort_at, input bit scramble);
    int          len;
    logic [63:0] d[$];
    logic [31:0] x;
    beat_t       b;
    len = (len_cfg == 0 || len_cfg > MAXW) ? MAXW : len_cfg;
    x = '0;
    for (int i = 0; i < n; i++) begin
      d.push_back({$urandom(), $urandom()});
      x = x ^ d[i][63:32] ^ d[i][31:0];
    end
    b.data = {16'hA5C3, exp_seq, len[15:0], 8'h00, 7'b0, CK};
    b.last = 1'b0; b.user = 1'b0; b.is_ts = 1'b0;
    exp_q.push_back(b);
    b.data = '0; b.is_ts = 1'b1;
    exp_q.push_back(b);
    b.is_ts = 1'b0;
    for (int i = 0; i < len; i++) begin
      b.data = (i < n) ? d[i] : 64'h0;
      b.user = (i >= n);
      b.last = !CK && (i == len - 1);
      exp_q.push_back(b);
    end
    if (CK) begin
      b.data = {16'h0000, 16'(n), x};
      b.user = 1'b0;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
    exp_seq++;
    exp_pkts++;
    cfg_pkt_len = 16'(len_cfg);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      if (i == drop_at) cfg_enable = 1'b0;
      send_beat(d[i], (i == n - 1) && (n < len || last_at_end));
      if (i == 0 && scramble) cfg_pkt_len = 16'($urandom);
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      @(posedge aclk);
      guard++;
    end
    if (exp_q.size() != 0) timeout({tag, "_drain"});
    repeat (3) @(posedge aclk);
    #1;
    check({tag, "_stat_seq"}, stat_seq, exp_seq);
    check({tag, "_pkt_count"}, stat_pkt_count, exp_pkts);
    check({tag, "_busy"}, stat_busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ctrl", {m_tvalid, m_tlast, m_tuser, m_tkeep, s_tready, stat_busy}, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_stats", {stat_seq, stat_pkt_count}, 0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    run_pkt(4, 4, 1'b0, -1, -1, 1'b0);
    drain("basic_len4");
    run_pkt(8, 3, 1'b1, -1, -1, 1'b0);
    drain("early_tlast");

    rnd_ready = 1'b1;
    gap_max   = 2;
    for (int p = 0; p < 100; p++)
      run_pkt(16, ($urandom % 4 == 0) ? int'($urandom_range(1, 16)) : 16,
              1'($urandom % 2), -1, -1, 1'b1);
    drain("random");
    rnd_ready = 1'b0;
    gap_max   = 0;

    force dut.seq_q = 16'hFFFF;
    @(posedge aclk);
    #1;
    release dut.seq_q;
    exp_seq = 16'hFFFF;
    run_pkt(1, 1, 1'b0, -1, -1, 1'b0);
    run_pkt(1, 1, 1'b0, -1, -1, 1'b0);
    drain("seq_wrap");

    run_pkt(0, MAXW, 1'b0, 10, -1, 1'b0);
    drain("len0_disable");
    s_tdata  = 64'hDEAD_BEEF_0000_0001;
    s_tvalid = 1'b1;
    repeat (40) @(posedge aclk);
    #1;
    check("disabled_idle", {stat_busy, m_tvalid, s_tready}, 0);
    s_tvalid   = 1'b0;
    cfg_enable = 1'b1;

    run_pkt(16, 16, 1'b0, -1, 5, 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    check("mid_payload_busy", stat_busy, 1);
    aresetn = 1'b0;
    #1;
    check("async_rst_ctrl", {m_tvalid, m_tlast, m_tuser, m_tkeep, s_tready, stat_busy}, 0);
    check("async_rst_stats", {stat_seq, stat_pkt_count}, 0);
    check("async_rst_tdata", m_tdata, 0);
    exp_q.delete();
    exp_seq  = '0;
    exp_pkts = 0;
    ts_seen  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    check("post_rst_pkt_count", stat_pkt_count, 0);
    run_pkt(3, 3, 1'b0, -1, -1, 1'b0);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
